interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port irq, input, 8 bits: external request lines; only bits 7:2 are used; bits 1:0 are ignored because they are reserved for ALU and stack overflow.
REQ-004 SHALL have port s_calli, input, 8 bits: one-hot dispatch vector from the control unit; nonzero means the indicated interrupt is entered this cycle.
REQ-005 SHALL have port s_reti, input, 1 bit: return-from-interrupt executed this cycle.
REQ-006 SHALL have port we_en, input, 1 bit: write strobe for the enable register.
REQ-007 SHALL have port en_in, input, 8 bits: new enable value; bits 1:0 are ignored.
REQ-008 SHALL have port min_bit_s, output, 8 bits: one-hot highest-priority request eligible for service, or 0 if none.
REQ-009 SHALL have port min_bit_a, output, 8 bits: one-hot highest-priority interrupt currently in service, or 0 if none.
REQ-010 SHALL have port int_a, output, 8 bits: full in-service register.
REQ-011 SHALL have port lost, output, 8 bits: sticky per-line flag marking a dropped request; bits 1:0 are always 0.

Function
REQ-012 Priority SHALL be fixed by bit index: lower index means higher priority, so the one-hot value compares numerically, with a smaller value being more urgent.
REQ-013 Edge detect: irq_q SHALL register irq[7:2] every cycle; rise[i] = irq[i] & ~irq_q[i].
REQ-014 pend[i] (i=7..2) SHALL be set at the edge where rise[i]=1, regardless of en[i].
- Latency: min_bit_s reflects the request in the cycle after irq is first sampled high.
REQ-015 If rise[i]=1 while pend[i] is already 1, pend[i] SHALL stay 1 and lost[i] SHALL be set.
REQ-016 Eligible vector SHALL be elig = pend & en & ~int_a; min_bit_s = isolate-lowest-set-bit(elig).
- min_bit_s is combinational from registers only; there is no combinational path from irq.
REQ-017 min_bit_a SHALL be isolate-lowest-set-bit(int_a); all outputs SHALL be 0 when their source vector is 0.
REQ-018 Dispatch: at an edge where s_calli has bit k set, int_a[k] SHALL be set and pend[k] cleared (k=7..2).
- For k=1:0, only int_a[k] is set.
- If s_calli is not one-hot, only its lowest set bit SHALL be honoured.
REQ-019 If rise[k] and dispatch of k coincide, pend[k] SHALL end at 1, because the new edge is a fresh request.
REQ-020 Return: at an edge where s_reti=1, the lowest set bit of int_a SHALL be cleared; s_reti with int_a=0 SHALL have no effect.
REQ-021 If s_reti and a nonzero s_calli coincide, the reti clear SHALL be computed on the pre-edge int_a, then the dispatch bit SHALL be set.
REQ-022 Nesting: the in-service bits SHALL nest up to 8 deep with no overflow state; a request is presented only if it outranks min_bit_a, which the control unit decides using min_bit_s.
REQ-023 Enable register en[7:2] SHALL load en_in[7:2] when we_en=1; en[1:0] SHALL read as constant 1.
REQ-024 Every we_en=1 SHALL clear lost[7:2].
REQ-025 Disabling a line SHALL NOT clear its pend bit; the request is presented again once the line is re-enabled.
REQ-026 Implementation SHALL be one clocked process plus combinational priority encoders, with no latches.

Reset
REQ-027 While reset=1 at an edge, the following SHALL be 0: pend, int_a, lost, en[7:2] and irq_q.
- Consequently min_bit_s = min_bit_a = int_a = lost = 0 in the following cycle.
REQ-028 Reset mid-service SHALL discard all nesting state.
- irq lines held high through reset SHALL NOT generate a request after reset deasserts, because irq_q is loaded with the current irq on the first post-reset edge.

Verification
REQ-029 Enable and dispatch:
- Stimulus: reset; we_en=1 with en_in=8'hFC; pulse irq[4] for 1 cycle.
- Response: min_bit_s=8'h10 next cycle; drive s_calli=8'h10 for 1 cycle, then min_bit_s=0, int_a=8'h10, min_bit_a=8'h10.
REQ-030 Preemption and return:
- Stimulus: with int_a=8'h10, pulse irq[2] and irq[6].
- Response: min_bit_s=8'h04.
- Stimulus: dispatch 8'h04.
- Response: int_a=8'h14, min_bit_a=8'h04, min_bit_s=8'h40.
- Stimulus: s_reti.
- Response: int_a=8'h10.
REQ-031 Lost request:
- Stimulus: en=0; give irq[3] two rising edges 3 cycles apart.
- Response: pend[3]=1, lost=8'h08, min_bit_s=0.
- Stimulus: write en_in=8'h08.
- Response: lost=0, min_bit_s=8'h08.
REQ-032 Overflow in service:
- Stimulus: s_calli=8'h01 with int_a=0.
- Response: int_a=8'h01.
- Stimulus: s_reti together with s_calli=8'h02.
- Response: int_a=8'h02.
REQ-033 Reset mid-service:
- Stimulus: int_a=8'h24, pend[5]=1, irq[7] held high; assert reset for 1 cycle.
- Response: all outputs 0, and they stay 0 for 5 cycles with irq[7] still high.
REQ-034 Coincident edge and dispatch:
- Stimulus: rise[5] in the same cycle as s_calli=8'h20.
- Response: int_a[5]=1, pend[5]=1, min_bit_s=0 while 5 is in service; after s_reti, min_bit_s=8'h20.

Source files
------------

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: edge-detected requests, per-line enables, nested in-service
// tracking and sticky lost-request flags. Lower bit index means higher priority.
module interrupt_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq,
    input  logic [7:0] s_calli,
    input  logic       s_reti,
    input  logic       we_en,
    input  logic [7:0] en_in,
    output logic [7:0] min_bit_s,
    output logic [7:0] min_bit_a,
    output logic [7:0] int_a,
    output logic [7:0] lost
);

    logic [7:2] irq_q;
    logic [7:2] pend_q, pend_d;
    logic [7:2] lost_q, lost_d;
    logic [7:2] en_q, en_d;
    logic [7:2] rise;
    logic [7:0] int_a_q, int_a_d;
    logic [7:0] elig;
    logic [7:0] calli_low;
    logic [7:0] reti_clr;
    // Low on the first edge after reset so lines held high through reset raise no request.
    logic       armed_q;

    // Lines 1:0 are driven internally; their external inputs are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{irq[1:0], en_in[1:0]};

    always_comb begin
        rise      = irq[7:2] & ~irq_q & {6{armed_q}};
        elig      = {pend_q, 2'b00} & {en_q, 2'b11} & ~int_a_q;
        // x & -x isolates the lowest set bit, i.e. the most urgent line.
        min_bit_s = elig & (~elig + 8'd1);
        min_bit_a = int_a_q & (~int_a_q + 8'd1);
        calli_low = s_calli & (~s_calli + 8'd1);
        reti_clr  = s_reti ? min_bit_a : 8'd0;
        int_a_d   = (int_a_q & ~reti_clr) | calli_low;
        // A fresh edge wins over a coincident dispatch of the same line.
        pend_d    = (pend_q & ~calli_low[7:2]) | rise;
        lost_d    = (we_en ? 6'd0 : lost_q) | (rise & pend_q);
        en_d      = we_en ? en_in[7:2] : en_q;
    end

    assign int_a = int_a_q;
    assign lost  = {lost_q, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pend_q  <= '0;
            lost_q  <= '0;
            en_q    <= '0;
            int_a_q <= '0;
            armed_q <= 1'b0;
        end else begin
            irq_q   <= irq[7:2];
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            en_q    <= en_d;
            int_a_q <= int_a_d;
            armed_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomized traffic
// compared cycle by cycle against a line-by-line behavioural model.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq = '0;
    logic [7:0] s_calli = '0;
    logic       s_reti = 1'b0;
    logic       we_en = 1'b0;
    logic [7:0] en_in = '0;
    logic [7:0] min_bit_s, min_bit_a, int_a, lost;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_pend = '0;
    logic [7:0] m_en   = 8'h03;
    logic [7:0] m_int  = '0;
    logic [7:0] m_lost = '0;
    logic [7:0] m_prev = '0;
    bit         m_armed = 1'b0;

    interrupt_controller dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .s_calli   (s_calli),
        .s_reti    (s_reti),
        .we_en     (we_en),
        .en_in     (en_in),
        .min_bit_s (min_bit_s),
        .min_bit_a (min_bit_a),
        .int_a     (int_a),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    // Index of the most urgent set bit, or -1 when empty.
    function automatic int first_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] onehot(input int idx);
        logic [7:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] exp_s();
        return onehot(first_idx(m_pend & m_en & ~m_int));
    endfunction

    function automatic logic [7:0] exp_a();
        return onehot(first_idx(m_int));
    endfunction

    // Advance model with the inputs presented before the edge, then clock the DUT.
    task automatic tick();
        logic [7:0] n_pend, n_en, n_int, n_lost;
        int k, r;
        if (reset) begin
            n_pend = '0; n_en = 8'h03; n_int = '0; n_lost = '0;
            m_prev = '0;
            m_armed = 1'b0;
        end else begin
            n_pend = m_pend;
            n_int  = m_int;
            n_lost = we_en ? 8'h00 : m_lost;
            n_en   = we_en ? (en_in | 8'h03) : m_en;
            r = first_idx(m_int);
            if (s_reti && r >= 0) n_int[r] = 1'b0;
            k = first_idx(s_calli);
            if (k >= 0) begin
                n_int[k] = 1'b1;
                if (k >= 2) n_pend[k] = 1'b0;
            end
            for (int i = 2; i < 8; i++) begin
                if (m_armed && irq[i] && !m_prev[i]) begin
                    if (m_pend[i]) n_lost[i] = 1'b1;
                    n_pend[i] = 1'b1;
                end
            end
            m_prev = irq & 8'hFC;
            m_armed = 1'b1;
        end
        @(posedge clk);
        #1;
        m_pend = n_pend; m_en = n_en; m_int = n_int; m_lost = n_lost;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({min_bit_s, min_bit_a, int_a, lost} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got s=%h a=%h int=%h lost=%h, want all 00",
                     min_bit_s, min_bit_a, int_a, lost);
        end
    endtask

    task automatic test_enable_dispatch();
        we_en = 1'b1; en_in = 8'hFC;
        tick();
        we_en = 1'b0; irq = 8'h10;
        tick();
        irq = 8'h00;
        n_tests++;
        if (min_bit_s !== 8'h10) begin
            n_fail++;
            $display("FAIL enable_request: min_bit_s got %h want 10", min_bit_s);
        end
        s_calli = 8'h10;
        tick();
        s_calli = 8'h00;
        n_tests++;
        if ({min_bit_s, int_a, min_bit_a} !== {8'h00, 8'h10, 8'h10}) begin
            n_fail++;
            $display("FAIL dispatch: got s=%h int=%h a=%h want s=00 int=10 a=10",
                     min_bit_s, int_a, min_bit_a);
        end
    endtask

    task automatic test_preempt();
        irq = 8'h44;
        tick();
        irq = 8'h00;
        n_tests++;
        if (min_bit_s !== 8'h04) begin
            n_fail++;
            $display("FAIL preempt_request: min_bit_s got %h want 04", min_bit_s);
        end
        s_calli = 8'h04;
        tick();
        s_calli = 8'h00;
        n_tests++;
        if ({int_a, min_bit_a, min_bit_s} !== {8'h14, 8'h04, 8'h40}) begin
            n_fail++;
            $display("FAIL nested_dispatch: got int=%h a=%h s=%h want int=14 a=04 s=40",
                     int_a, min_bit_a, min_bit_s);
        end
        s_reti = 1'b1;
        tick();
        n_tests++;
        if (int_a !== 8'h10) begin
            n_fail++;
            $display("FAIL nested_return: int_a got %h want 10", int_a);
        end
        tick();
        s_reti = 1'b0;
        s_calli = 8'h40;
        tick();
        s_calli = 8'h00; s_reti = 1'b1;
        tick();
        s_reti = 1'b0;
        n_tests++;
        if ({int_a, min_bit_s} !== 16'h0) begin
            n_fail++;
            $display("FAIL preempt_cleanup: got int=%h s=%h want 00 00", int_a, min_bit_s);
        end
    endtask

    task automatic test_lost();
        we_en = 1'b1; en_in = 8'h00;
        tick();
        we_en = 1'b0; irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        tick();
        irq = 8'h08;
        tick();
        irq = 8'h00;
        n_tests++;
        if ({lost, min_bit_s} !== {8'h08, 8'h00}) begin
            n_fail++;
            $display("FAIL lost_flag: got lost=%h s=%h want lost=08 s=00", lost, min_bit_s);
        end
        we_en = 1'b1; en_in = 8'h08;
        tick();
        we_en = 1'b0;
        n_tests++;
        if ({lost, min_bit_s} !== {8'h00, 8'h08}) begin
            n_fail++;
            $display("FAIL lost_clear: got lost=%h s=%h want lost=00 s=08", lost, min_bit_s);
        end
        s_calli = 8'h08;
        tick();
        s_calli = 8'h00; s_reti = 1'b1;
        tick();
        s_reti = 1'b0;
    endtask

    task automatic test_overflow();
        s_calli = 8'h01;
        tick();
        n_tests++;
        if (int_a !== 8'h01) begin
            n_fail++;
            $display("FAIL overflow_enter: int_a got %h want 01", int_a);
        end
        s_calli = 8'h02; s_reti = 1'b1;
        tick();
        n_tests++;
        if (int_a !== 8'h02) begin
            n_fail++;
            $display("FAIL reti_with_call: int_a got %h want 02", int_a);
        end
        s_calli = 8'h00;
        tick();
        s_reti = 1'b0;
    endtask

    task automatic test_coincident();
        we_en = 1'b1; en_in = 8'hFC;
        tick();
        we_en = 1'b0; irq = 8'h20; s_calli = 8'h20;
        tick();
        irq = 8'h00; s_calli = 8'h00;
        n_tests++;
        if (int_a[5] !== 1'b1 || min_bit_s !== 8'h00) begin
            n_fail++;
            $display("FAIL coincident_edge: got int=%h s=%h want int[5]=1 s=00", int_a, min_bit_s);
        end
        s_reti = 1'b1;
        tick();
        s_reti = 1'b0;
        n_tests++;
        if (min_bit_s !== 8'h20) begin
            n_fail++;
            $display("FAIL coincident_repend: min_bit_s got %h want 20", min_bit_s);
        end
        s_calli = 8'h20;
        tick();
        s_calli = 8'h00; s_reti = 1'b1;
        tick();
        s_reti = 1'b0;
    endtask

    task automatic test_reset_mid();
        s_calli = 8'h04;
        tick();
        s_calli = 8'h20;
        tick();
        s_calli = 8'h00; irq = 8'h20;
        tick();
        irq = 8'hA0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({min_bit_s, min_bit_a, int_a, lost} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_service: got s=%h a=%h int=%h lost=%h want all 00",
                     min_bit_s, min_bit_a, int_a, lost);
        end
        we_en = 1'b1; en_in = 8'hFC;
        for (int c = 0; c < 5; c++) begin
            tick();
            we_en = 1'b0;
            n_tests++;
            if ({min_bit_s, min_bit_a, int_a, lost} !== 32'h0) begin
                n_fail++;
                $display("FAIL held_irq_after_reset cycle %0d: got s=%h a=%h int=%h lost=%h", c,
                         min_bit_s, min_bit_a, int_a, lost);
            end
        end
        irq = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] want_s, want_a;
        for (int c = 0; c < 800; c++) begin
            reset  = ($urandom_range(0, 80) == 0);
            we_en  = ($urandom_range(0, 9) == 0);
            en_in  = 8'($urandom);
            // Keep irq steady during enable writes so lost clear and lost set never coincide.
            if (!we_en) irq = irq ^ (8'($urandom) & 8'($urandom));
            case ($urandom_range(0, 3))
                0:       s_calli = min_bit_s;
                1:       s_calli = 8'($urandom);
                default: s_calli = 8'h00;
            endcase
            s_reti = ($urandom_range(0, 3) == 0);
            tick();
            want_s = exp_s();
            want_a = exp_a();
            n_tests++;
            if ({min_bit_s, min_bit_a, int_a, lost} !== {want_s, want_a, m_int, m_lost}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got s=%h a=%h int=%h lost=%h want s=%h a=%h int=%h lost=%h",
                         c, min_bit_s, min_bit_a, int_a, lost, want_s, want_a, m_int, m_lost);
            end
        end
        reset = 1'b0; we_en = 1'b0; s_calli = 8'h00; s_reti = 1'b0;
    endtask

    initial begin
        test_reset();
        test_enable_dispatch();
        test_preempt();
        test_lost();
        test_overflow();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
